// File: rtl/pedestrian_request_pkg.sv
// Shared definitions for the pedestrian request conditioner.
// Provides the semaphore light encodings, the request FSM state type and
// the default debounce / hold-off durations.
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] DEB_CYCLES_DEF     = 8'd4;
  localparam logic [7:0] HOLDOFF_CYCLES_DEF = 8'd8;

  // Only the exact red one-hot code counts; illegal codes read as not red.
  function automatic logic is_red(input logic [2:0] a);
    return a == LUZ_VERMELHO;
  endfunction

endpackage

// File: rtl/pedestrian_request_if.sv
// Signal bundle between the button conditioner and its surroundings.
//   bt_raw   raw push-button (asynchronous, bouncing)
//   a_state  semaphore A light, tapped from the controller
//   bt       one-cycle request pulse to the controller
//   pending  request lamp
//   presses  saturating count of accepted presses
// master drives the button / light side, slave is the conditioner.
interface pedestrian_request_if;
  logic       bt_raw;
  logic [2:0] a_state;
  logic       bt;
  logic       pending;
  logic [7:0] presses;

  modport master (output bt_raw, a_state, input bt, pending, presses);
  modport slave  (input bt_raw, a_state, output bt, pending, presses);
endinterface

// File: rtl/pedestrian_request_debounce.sv
// Two-flop synchroniser followed by a debounce counter.
//   clk, rst  clock, asynchronous active-low reset
//   bt_raw    raw asynchronous button
//   deb       debounced level; changes only after DEB_CYCLES consecutive
//             synchronised samples that differ from it (both edges)
module debounce
  import semaforo_pkg::*;
#(
  parameter logic [7:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bt_raw,
  output logic deb
);

  localparam logic [7:0] DEB_LAST = DEB_CYCLES - 8'd1;

  logic [1:0] sync;   // sync[0] = s1, sync[1] = s2
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], bt_raw};
      // Any sample agreeing with the current level restarts the run.
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pedestrian_request.sv
// Pedestrian push-button conditioner feeding the traffic controller's bt.
//   clk, rst  clock, asynchronous active-low reset
//   io        slave side of pedestrian_request_if:
//             bt_raw/a_state in, bt/pending/presses out
// Each debounced rising edge is a press. From IDLE a press issues one bt
// pulse; the lamp stays lit until A is seen red, then a hold-off window
// swallows further presses. presses counts every press, in any state.
module pedestrian_request
  import semaforo_pkg::*;
#(
  parameter logic [7:0] DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter logic [7:0] HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pedestrian_request_if.slave io
);

  localparam logic [7:0] HOLD_LAST = HOLDOFF_CYCLES - 8'd1;

  logic       deb, deb_d, press;
  state_t     state;
  logic [7:0] hcnt;
  logic [7:0] presses_q;
  logic       bt_q, pend_q;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .bt_raw (io.bt_raw),
    .deb    (deb)
  );

  assign press = deb & ~deb_d;

  // Outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_d     <= 1'b0;
      state     <= IDLE;
      hcnt      <= '0;
      presses_q <= '0;
      bt_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      deb_d <= deb;
      if (press && presses_q != 8'hff) presses_q <= presses_q + 8'd1;
      bt_q <= 1'b0;
      case (state)
        IDLE: if (press) begin
          state  <= ISSUE;
          bt_q   <= 1'b1;
          pend_q <= 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: if (is_red(io.a_state)) begin
          state  <= HOLDOFF;
          hcnt   <= '0;
          pend_q <= 1'b0;
        end
        HOLDOFF: begin
          // A press on the final hold-off cycle is lost on purpose.
          if (hcnt == HOLD_LAST) state <= IDLE;
          else                   hcnt  <= hcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.bt      = bt_q;
  assign io.pending = pend_q;
  assign io.presses = presses_q;

endmodule

// File: doc/pedestrian_request.md
Name: pedestrian_request

Overview:
- Upstream conditioner for the traffic-light controller's `bt` input.
- Takes the raw pedestrian push-button, synchronises and debounces it, and turns each accepted press into exactly one single-cycle `bt` pulse.
- Holds a "request pending" lamp until semaphore A shows red, then enforces a hold-off before the next request is accepted.
- Output `bt` connects directly to the controller's `bt`. Input `a_state` taps the controller's `A` output.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (1..255, 8-bit counter).
- HOLDOFF_CYCLES, 8, cycles after A reaches red during which new presses raise no request (1..255, 8-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- bt_raw  in  1  raw push-button, asynchronous, may bounce.
- a_state  in  3  semaphore A state; encoding defined in the package.
- bt  out  1  one-cycle request pulse to the controller.
- pending  out  1  request lamp: high from issue until A is observed red.
- presses  out  8  saturating count of accepted (debounced) presses.

Behaviour:
- Reset (rst=0, asynchronous) forces the following; reset mid-operation aborts any request, and no pulse is emitted after release:
  - sync flops = 0, debounced level `deb` = 0, deb_d = 0, debounce count = 0, hold-off count = 0
  - state = IDLE, bt = 0, pending = 0, presses = 0
- Synchroniser: two flops, s1 <= bt_raw, s2 <= s1.
- Debounce:
  - If s2 == deb: count <= 0.
  - Else if count == DEB_CYCLES-1: deb <= s2 and count <= 0.
  - Else: count <= count+1.
  - Both press and release are debounced.
- Edge: deb_d <= deb; press = deb & ~deb_d, high for one cycle.
- presses increments on every press and saturates at 255, in any state.
- FSM (Moore):
  - IDLE: press -> ISSUE; otherwise stay.
  - ISSUE: bt = 1, pending = 1; always -> WAIT next cycle.
  - WAIT: pending = 1; if a_state == LUZ_VERMELHO -> HOLDOFF and load hold-off count = 0; presses ignored.
  - HOLDOFF: pending = 0; count++; when count == HOLDOFF_CYCLES-1 -> IDLE; presses ignored.
- bt and pending are registered outputs decoded from state, so they carry no glitches.
- Latency: raw rising edge first sampled at edge e0 (stable thereafter) -> bt high exactly between edges e0+DEB_CYCLES+2 and e0+DEB_CYCLES+3.
- Boundary cases:
  - A already red when ISSUE is left: WAIT lasts one cycle, then HOLDOFF.
  - Illegal a_state encoding is treated as not red; the block stays in WAIT.
  - A press that coincides with the last HOLDOFF cycle is dropped; it still counts in `presses`.
  - A button held continuously produces only one request; it must be released (debounced) and pressed again.
  - DEB_CYCLES = 1 means a level is accepted after one differing cycle.

Decomposition:
- Package `semaforo_pkg`:
  - light encodings LUZ_VERDE = 3'b001, LUZ_AMARELO = 3'b010, LUZ_VERMELHO = 3'b100
  - FSM state encoding IDLE / ISSUE / WAIT / HOLDOFF (2 bits)
  - default duration constants (8-bit)
- One sub-module, `debounce`: synchroniser plus debounce counter, parameterised by DEB_CYCLES, output `deb`. The FSM, edge detect and counters stay in the top.

Test Plan (DEB_CYCLES = 4, HOLDOFF_CYCLES = 8, a_state = LUZ_VERDE unless stated):
- Reset: rst=0 with bt_raw=1 toggling -> bt=0, pending=0, presses=0 throughout. Release rst with bt_raw=0 -> outputs remain 0.
- Clean press: bt_raw rises at e0 and holds 20 cycles -> bt high exactly between e6 and e7; pending high from e6; presses = 1; no second pulse while held.
- Bounce: bt_raw high 3 cycles, low 1, high 3, low -> no bt, presses = 0. Then bt_raw high 4 cycles -> bt pulse, presses = 1.
- Serve: after the pulse hold a_state green 5 cycles, then LUZ_VERMELHO -> pending falls one edge after red is sampled. A press during WAIT or the next 8 cycles -> no bt, presses increments. A press after hold-off -> new bt.
- Reset mid-WAIT: pull rst low for 1 cycle while pending=1 -> pending = 0 immediately (asynchronous), presses = 0, state IDLE, no bt after release.
- Saturation: 260 clean press/release cycles, each ending in a served request -> presses = 255 and stays there.
